// File: rtl/usbf_mem_arb_if.sv
// Bus bundle between the USB protocol engine (M0), the Wishbone buffer path (M1)
// and the single-port buffer SSRAM, as seen around the memory arbiter.
interface usbf_mem_arb_if #(
   parameter int SSRAM_HADR = 14
);
   // M0: USB protocol engine
   logic [SSRAM_HADR:0] madr_i;
   logic [31:0]         mdin_i;
   logic [31:0]         mdout_o;
   logic                mwe_i;
   logic                mreq_i;
   logic                mack_o;

   // M1: Wishbone buffer access
   logic [SSRAM_HADR:0] wadr_i;
   logic [31:0]         wdin_i;
   logic [31:0]         wdout_o;
   logic                wwe_i;
   logic                wreq_i;
   logic                wack_o;
   logic                wb_stall_o;

   // SSRAM side
   logic [SSRAM_HADR:0] sram_adr_o;
   logic [31:0]         sram_dout_o;
   logic [31:0]         sram_din_i;
   logic                sram_we_o;
   logic                sram_re_o;

   // Arbiter view
   modport slave (
      input  madr_i, mdin_i, mwe_i, mreq_i,
      output mdout_o, mack_o,
      input  wadr_i, wdin_i, wwe_i, wreq_i,
      output wdout_o, wack_o, wb_stall_o,
      output sram_adr_o, sram_dout_o, sram_we_o, sram_re_o,
      input  sram_din_i
   );

   // Environment view (masters plus the SSRAM model)
   modport master (
      output madr_i, mdin_i, mwe_i, mreq_i,
      input  mdout_o, mack_o,
      output wadr_i, wdin_i, wwe_i, wreq_i,
      input  wdout_o, wack_o, wb_stall_o,
      input  sram_adr_o, sram_dout_o, sram_we_o, sram_re_o,
      output sram_din_i
   );
endinterface

// File: rtl/usbf_mem_arb.sv
// Two-master arbiter in front of the USB buffer SSRAM: the protocol engine (M0) always
// wins and is never stalled; the Wishbone path (M1) takes free slots and flags starvation.
module usbf_mem_arb #(
   parameter int SSRAM_HADR = 14,
   parameter int STALL_LIM  = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   usbf_mem_arb_if.slave   bus
);

   typedef enum logic {
      W_IDLE = 1'b0,
      W_ACK  = 1'b1
   } w_state_t;

   localparam logic [8:0] STALL_LIM_W = 9'(STALL_LIM);

   w_state_t            state_q, state_d;
   logic                mack_q, mack_d;
   logic                wack_q, wack_d;
   logic                stall_q, stall_d;
   logic [7:0]          cnt_q, cnt_d;

   logic                m_gnt;
   logic                w_gnt;
   logic                w_idle;
   logic                w_denied;
   logic [8:0]          cnt_inc;

   logic [SSRAM_HADR:0] sram_adr;
   logic [31:0]         sram_dout;
   logic                sram_we;
   logic                sram_re;

   // Grants are purely combinational; WB is blocked in W_ACK so a held request
   // is not serviced twice.
   always_comb begin
      w_idle   = (state_q == W_IDLE);
      m_gnt    = bus.mreq_i;
      w_gnt    = bus.wreq_i & ~bus.mreq_i & w_idle;
      w_denied = bus.wreq_i & ~w_gnt & w_idle;
   end

   always_comb begin
      sram_adr  = bus.wadr_i;
      sram_dout = bus.wdin_i;
      sram_we   = 1'b0;
      sram_re   = 1'b0;
      if (m_gnt) begin
         sram_adr  = bus.madr_i;
         sram_dout = bus.mdin_i;
         sram_we   = bus.mwe_i;
         sram_re   = ~bus.mwe_i;
      end else if (w_gnt) begin
         sram_we   = bus.wwe_i;
         sram_re   = ~bus.wwe_i;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         W_IDLE:  if (w_gnt) state_d = W_ACK;
         W_ACK:   state_d = W_IDLE;
         default: state_d = W_IDLE;
      endcase
      wack_d = (state_d == W_ACK);
      mack_d = bus.mreq_i;
   end

   // Starvation tracking: counts consecutive denied idle cycles, saturating at 255.
   always_comb begin
      cnt_d   = cnt_q;
      stall_d = stall_q;
      cnt_inc = {1'b0, cnt_q} + 9'd1;
      if (w_gnt) begin
         cnt_d   = 8'd0;
         stall_d = 1'b0;
      end else if (w_denied) begin
         cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_inc[7:0];
         if (cnt_inc >= STALL_LIM_W) begin
            stall_d = 1'b1;
         end
      end else if (w_idle && !bus.wreq_i) begin
         cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= W_IDLE;
         mack_q  <= 1'b0;
         wack_q  <= 1'b0;
         stall_q <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         mack_q  <= mack_d;
         wack_q  <= wack_d;
         stall_q <= stall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.sram_adr_o  = sram_adr;
   assign bus.sram_dout_o = sram_dout;
   assign bus.sram_we_o   = sram_we;
   assign bus.sram_re_o   = sram_re;

   // Read data comes straight from the SSRAM's output register to both masters.
   assign bus.mdout_o     = bus.sram_din_i;
   assign bus.wdout_o     = bus.sram_din_i;
   assign bus.mack_o      = mack_q;
   assign bus.wack_o      = wack_q;
   assign bus.wb_stall_o  = stall_q;

endmodule

// File: doc/usbf_mem_arb.md
Name: usbf_mem_arb

Overview:
- Two-master arbiter sitting directly upstream of the single-port USB buffer SSRAM.
- Master 0 is the USB protocol engine. It has absolute priority and fixed timing.
- Master 1 is the Wishbone buffer-access path. It uses a req/ack handshake and waits for free slots.
- The block muxes address, data and strobes onto the SSRAM, returns read data with the SSRAM's 1-cycle latency, and flags Wishbone starvation.

Parameters:
- SSRAM_HADR, 14, SSRAM address MSB; address buses are SSRAM_HADR+1 bits.
- STALL_LIM, 255, consecutive denied WB-request cycles before wb_stall_o asserts; valid range 1..255.

Ports:
- clk_i  in  1  clock; all registers on its rising edge
- rst_i  in  1  asynchronous, active-high reset
- madr_i  in  SSRAM_HADR+1  M0 word address
- mdin_i  in  32  M0 write data
- mdout_o  out  32  M0 read data; valid while mack_o=1
- mwe_i  in  1  M0 write enable; qualified by mreq_i
- mreq_i  in  1  M0 access request; one access per high cycle
- mack_o  out  1  M0 access done; mreq_i delayed one cycle
- wadr_i  in  SSRAM_HADR+1  WB word address
- wdin_i  in  32  WB write data
- wdout_o  out  32  WB read data; valid while wack_o=1
- wwe_i  in  1  WB write enable
- wreq_i  in  1  WB request; held high until wack_o
- wack_o  out  1  WB one-cycle ack pulse
- wb_stall_o  out  1  WB starvation flag
- sram_adr_o  out  SSRAM_HADR+1  SSRAM address
- sram_dout_o  out  32  SSRAM write data
- sram_din_i  in  32  SSRAM read data; registered in the SSRAM, valid the cycle after re
- sram_we_o  out  1  SSRAM write enable
- sram_re_o  out  1  SSRAM read enable

Behaviour:
- Reset values: mack_o=0, wack_o=0, wb_stall_o=0, WB FSM=W_IDLE, stall counter=0.
  - With no requests, sram_we_o=0 and sram_re_o=0.
- Grant (combinational, per cycle):
  - m_gnt = mreq_i.
  - w_gnt = wreq_i & ~mreq_i & (state==W_IDLE).
- SSRAM mux:
  - m_gnt: sram_adr_o=madr_i, sram_dout_o=mdin_i, sram_we_o=mwe_i, sram_re_o=~mwe_i.
  - w_gnt: the same assignments from the WB inputs.
  - No grant: sram_adr_o=wadr_i, sram_dout_o=wdin_i, we=0, re=0.
  - sram_we_o and sram_re_o are never both 1.
- M0 path:
  - mack_o is registered mreq_i, so a request in cycle N acks in N+1.
  - mdout_o = sram_din_i, passed straight through.
  - Back-to-back M0 requests are serviced every cycle. M0 is never stalled.
- WB FSM:
  - W_IDLE -> W_ACK on w_gnt. Otherwise stay in W_IDLE.
  - W_ACK -> W_IDLE unconditionally.
  - wack_o = (state==W_ACK), registered; wdout_o = sram_din_i.
  - In W_ACK, wreq_i is still high from the finishing transfer and is not re-granted.
  - If wreq_i is still high in the following W_IDLE cycle, it is treated as a new transfer.
  - Max WB throughput is one access per 2 cycles.
- WB write latency:
  - Write is committed at the grant-cycle edge; ack follows one cycle later.
  - A WB read issued after a WB write ack returns the new data.
- Simultaneous mreq_i & wreq_i: M0 wins. WB stays in W_IDLE, attributes held, and retries each cycle.
- Stall counter (8-bit):
  - Increments, saturating at 255, each cycle with wreq_i & ~w_gnt & state==W_IDLE.
  - Clears to 0 on w_gnt.
  - wb_stall_o is registered, set when counter+1 reaches STALL_LIM, and cleared on w_gnt.
  - Stall is a status flag only; priority is never changed.
- wreq_i dropped before grant: counter clears to 0, no access, no ack.
- Reset mid-transfer: FSM returns to W_IDLE, any pending ack is lost, counter cleared. In-flight SSRAM writes already clocked remain.

Test Plan:
- M0 write 0xDEADBEEF @0x0010 in cycle N, then read @0x0010 in N+1 -> sram_we_o=1 in N; mack_o=1 in N+1 and N+2; mdout_o=0xDEADBEEF in N+2.
- WB read @0x0100 (preloaded 0x12345678), no M0 traffic -> sram_re_o=1 in grant cycle N; wack_o=1 only in N+1 with wdout_o=0x12345678; no re-grant in N+1.
- mreq_i high for cycles N..N+3 while wreq_i high from N -> WB granted at N+4, wack_o at N+5; M0 acks at N+1..N+4; never we&re together.
- STALL_LIM=4, M0 saturates 10 cycles with WB pending -> wb_stall_o rises after 4th denied cycle; clears the cycle after WB grant.
- WB wreq_i held 3 transfers, addresses 0x1,0x2,0x3 -> grants every 2nd cycle, exactly 3 one-cycle wack_o pulses.
- Assert rst_i in W_ACK cycle -> wack_o=0 immediately (async); after release FSM idle, counter=0, new WB access completes normally.
